grill_star_actuator: RTL and testbench
======================================

// Module: grill_star_actuator
// PURPOSE
// Plant-side end of the grill/star motor interface. Receives the 4-bit motor command word
// from the star hiding controller and drives the matching 2-bit position codes back to it.
// Grill and star travel are modelled by step counters, with mechanical interlocks and
// command-fault detection. Used in bench/top as the closed-loop partner of the controller.
// PARAMETERS
// GRILL_TRAVEL  8  steps between grill closed (0) and grill fully open (GRILL_TRAVEL); >=2
// STAR_TRAVEL   6  steps between star up (0) and star hidden (STAR_TRAVEL); >=2
// STEP_DIV      1  clocks per position step (prescaler); >=1
// PORTS
// i_clk          in   1  system clock, all logic on rising edge
// i_rst          in   1  synchronous reset, active-high
// i_motor_cmd    in   4  [3] grill open, [2] grill close, [1] star hide, [0] star extend
// o_grill_pos    out  2  00 closed, 01 fully open, 10 mid-travel
// o_star_pos     out  2  00 up (shown), 01 hidden, 10 mid-travel
// o_grill_moving out  1  grill counter stepping this cycle (command legal, not at end stop)
// o_star_moving  out  1  star counter stepping this cycle
// o_fault        out  1  registered: previous sampled command was illegal
// BEHAVIOUR
// - Reset (i_rst=1 at edge): grill_cnt=0, star_cnt=0, prescaler=0, o_fault=0;
//   outputs: o_grill_pos=00, o_star_pos=00, moving=0. Reset overrides everything, mid-travel too.
// - Counters: width $clog2(TRAVEL+1), saturate at 0 and TRAVEL, never wrap.
// - Pos decode: cnt==0 -> 00, cnt==TRAVEL -> 01, else 10. Combinational from counter registers.
// - Prescaler: counts 0..STEP_DIV-1, wraps; tick=1 when ==STEP_DIV-1 (always 1 if STEP_DIV=1).
//   Runs freely; not cleared by command changes.
// - Per-axis FSM, state derived from counter and direction: HOME, MOVE_OUT, MOVE_IN, STOP_MID, END.
//   No command in any state -> HOME/STOP_MID/END as per counter (motor off, position held).
// - Illegal command (fault, no axis moves this cycle):
//   a) cmd[3]&cmd[2] or cmd[1]&cmd[0] (opposing bits);
//   b) any grill bit and any star bit together;
//   c) star bit while grill_cnt!=GRILL_TRAVEL (star only moves with grill fully open);
//   d) grill bit while star_cnt not 0 and not STAR_TRAVEL (grill never moves with star mid-travel).
// - Legal grill open: on tick, grill_cnt+1 unless ==GRILL_TRAVEL. Close: -1 unless ==0.
//   Star hide: star_cnt+1 unless ==STAR_TRAVEL; extend: -1 unless ==0.
// - Command into an end stop: no step, moving=0, no fault (motor stalls).
// - o_*_moving: combinational = legal cmd for that axis & not at the end stop in that direction.
//   Asserted regardless of tick.
// - o_fault: registered each edge from illegal(i_motor_cmd); high exactly one cycle per illegal
//   sampled cycle. Not sticky.
// - Latency: a step taken at edge N is visible on o_*_pos immediately after edge N.
// - Command 0000: hold everything, fault 0.
// TESTING (GRILL_TRAVEL=4, STAR_TRAVEL=3, STEP_DIV=1 unless noted)
// 1. Reset 2 cycles, cmd=0000 -> grill_pos=00, star_pos=00, moving=0, fault=0.
// 2. cmd=1000 for 6 cycles -> grill_pos 10 after edges 1-3, 01 after edge 4;
//    edges 5-6 stay 01, grill_moving=0.
// 3. From open: cmd=0010 for 3 cycles -> star_pos 10,10,01. Then cmd=0100 for 4 cycles ->
//    grill_pos 10,10,10,00 with star_pos=01 held.
// 4. Grill closed, cmd=0010 -> star_pos stays 00, o_fault=1 one cycle.
//    cmd=1100 -> fault=1, no motion. cmd=1010 -> fault=1.
// 5. cmd=1000 for 2 cycles, then 0000 -> grill_pos=10 held indefinitely (STOP_MID).
//    i_rst=1 for 1 cycle -> grill_pos=00.
// 6. STEP_DIV=3: cmd=1000 for 12 cycles from reset -> grill_cnt increments every 3rd edge,
//    grill_pos=01 after edge 12, grill_moving=1 throughout until then.

Source files
------------

// File: rtl/grill_star_actuator.sv
// Plant model for the grill/star motors: step counters with interlocks, position codes and fault flag.
// Latency: a step taken at edge N shows on the position outputs right after edge N; no backpressure, a command is sampled every clock.
module grill_star_actuator #(
  parameter int GRILL_TRAVEL = 8,
  parameter int STAR_TRAVEL  = 6,
  parameter int STEP_DIV     = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_motor_cmd,
  output logic [1:0] o_grill_pos,
  output logic [1:0] o_star_pos,
  output logic       o_grill_moving,
  output logic       o_star_moving,
  output logic       o_fault
);

  localparam int GW = $clog2(GRILL_TRAVEL + 1);
  localparam int SW = $clog2(STAR_TRAVEL + 1);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [GW-1:0] G_END  = GW'(GRILL_TRAVEL);
  localparam logic [SW-1:0] S_END  = SW'(STAR_TRAVEL);
  localparam logic [PW-1:0] P_LAST = PW'(STEP_DIV - 1);

  typedef enum logic [2:0] {HOME, MOVE_OUT, MOVE_IN, STOP_MID, AT_END} axis_st_e;

  logic [GW-1:0] grill_cnt, grill_nxt;
  logic [SW-1:0] star_cnt, star_nxt;
  logic [PW-1:0] presc;
  axis_st_e      grill_st, grill_st_nxt, star_st, star_st_nxt;
  logic          tick, grill_any, star_any, illegal;

  always_comb begin
    tick      = (presc == P_LAST);
    grill_any = i_motor_cmd[3] | i_motor_cmd[2];
    star_any  = i_motor_cmd[1] | i_motor_cmd[0];
    // Star only travels with the grill fully open; grill never travels with the star mid-way.
    illegal   = (i_motor_cmd[3] & i_motor_cmd[2]) | (i_motor_cmd[1] & i_motor_cmd[0])
              | (grill_any & star_any)
              | (star_any & (grill_cnt != G_END))
              | (grill_any & (star_cnt != '0) & (star_cnt != S_END));

    o_grill_moving = !illegal && ((i_motor_cmd[3] && grill_cnt != G_END) ||
                                  (i_motor_cmd[2] && grill_cnt != '0));
    o_star_moving  = !illegal && ((i_motor_cmd[1] && star_cnt != S_END) ||
                                  (i_motor_cmd[0] && star_cnt != '0));

    grill_nxt = grill_cnt;
    if (tick && o_grill_moving)
      grill_nxt = i_motor_cmd[3] ? grill_cnt + 1'b1 : grill_cnt - 1'b1;
    star_nxt = star_cnt;
    if (tick && o_star_moving)
      star_nxt = i_motor_cmd[1] ? star_cnt + 1'b1 : star_cnt - 1'b1;

    if (grill_nxt == '0)         grill_st_nxt = HOME;
    else if (grill_nxt == G_END) grill_st_nxt = AT_END;
    else if (o_grill_moving)     grill_st_nxt = i_motor_cmd[3] ? MOVE_OUT : MOVE_IN;
    else                         grill_st_nxt = STOP_MID;

    if (star_nxt == '0)          star_st_nxt = HOME;
    else if (star_nxt == S_END)  star_st_nxt = AT_END;
    else if (o_star_moving)      star_st_nxt = i_motor_cmd[1] ? MOVE_OUT : MOVE_IN;
    else                         star_st_nxt = STOP_MID;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grill_cnt <= '0;
      star_cnt  <= '0;
      presc     <= '0;
      grill_st  <= HOME;
      star_st   <= HOME;
      o_fault   <= 1'b0;
    end else begin
      grill_cnt <= grill_nxt;
      star_cnt  <= star_nxt;
      presc     <= (presc == P_LAST) ? '0 : presc + 1'b1;
      grill_st  <= grill_st_nxt;
      star_st   <= star_st_nxt;
      o_fault   <= illegal;
    end
  end

  // State mirrors the counter end stops, so decoding it equals decoding the counters.
  always_comb begin
    o_grill_pos = (grill_st == HOME) ? 2'b00 : (grill_st == AT_END) ? 2'b01 : 2'b10;
    o_star_pos  = (star_st  == HOME) ? 2'b00 : (star_st  == AT_END) ? 2'b01 : 2'b10;
  end

endmodule

// File: tb/tb_grill_star_actuator.sv
// Two actuators (STEP_DIV 1 and 3) share one random command stream and are scored against a position model.
module tb_grill_star_actuator;
  localparam int GT = 4;
  localparam int ST = 3;

  logic       clk;
  logic       rst;
  logic [3:0] cmd;
  logic [1:0] gpos[2];
  logic [1:0] spos[2];
  logic       gmov[2];
  logic       smov[2];
  logic       flt[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  grill_star_actuator #(.GRILL_TRAVEL(GT), .STAR_TRAVEL(ST), .STEP_DIV(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_motor_cmd(cmd),
    .o_grill_pos(gpos[0]), .o_star_pos(spos[0]),
    .o_grill_moving(gmov[0]), .o_star_moving(smov[0]), .o_fault(flt[0])
  );

  grill_star_actuator #(.GRILL_TRAVEL(GT), .STAR_TRAVEL(ST), .STEP_DIV(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_motor_cmd(cmd),
    .o_grill_pos(gpos[1]), .o_star_pos(spos[1]),
    .o_grill_moving(gmov[1]), .o_star_moving(smov[1]), .o_fault(flt[1])
  );

  typedef struct { logic gm[2]; logic sm[2]; } mov_t;
  typedef struct { logic [1:0] gp[2]; logic [1:0] sp[2]; logic f[2]; } reg_t;

  mov_t q_mov[$];
  reg_t q_reg[$];
  int   m_g[2]  = '{0, 0};
  int   m_s[2]  = '{0, 0};
  int   m_ph[2] = '{0, 0};
  int   checks  = 0;
  int   errors  = 0;

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] pos_code(input int c, input int t);
    return (c == 0) ? 2'b00 : (c == t) ? 2'b01 : 2'b10;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: the model predicts this cycle's moving flags and the post-edge outputs.
  task automatic drive(input logic r, input logic [3:0] c);
    mov_t mv;
    reg_t rg;
    bit   gb, sb, bad, tick;
    @(negedge clk);
    rst = r;
    cmd = c;
    for (int k = 0; k < 2; k++) begin
      gb  = c[3] || c[2];
      sb  = c[1] || c[0];
      bad = (c[3] && c[2]) || (c[1] && c[0]) || (gb && sb) ||
            (sb && m_g[k] != GT) || (gb && m_s[k] != 0 && m_s[k] != ST);
      mv.gm[k] = !bad && ((c[3] && m_g[k] < GT) || (c[2] && m_g[k] > 0));
      mv.sm[k] = !bad && ((c[1] && m_s[k] < ST) || (c[0] && m_s[k] > 0));
      if (r) begin
        m_g[k] = 0; m_s[k] = 0; m_ph[k] = 0;
        rg.f[k] = 1'b0;
      end else begin
        tick = (m_ph[k] == div_of(k) - 1);
        if (tick && mv.gm[k]) m_g[k] += c[3] ? 1 : -1;
        if (tick && mv.sm[k]) m_s[k] += c[1] ? 1 : -1;
        m_ph[k] = (m_ph[k] + 1) % div_of(k);
        rg.f[k] = bad;
      end
      rg.gp[k] = pos_code(m_g[k], GT);
      rg.sp[k] = pos_code(m_s[k], ST);
    end
    q_mov.push_back(mv);
    q_reg.push_back(rg);
  endtask

  initial begin : mon_mov
    mov_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q_mov.size() > 0) begin
        e = q_mov.pop_front();
        for (int k = 0; k < 2; k++) begin
          check($sformatf("grill_moving[%0d]", k), {1'b0, gmov[k]}, {1'b0, e.gm[k]});
          check($sformatf("star_moving[%0d]", k), {1'b0, smov[k]}, {1'b0, e.sm[k]});
        end
      end
    end
  end

  initial begin : mon_reg
    reg_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_reg.size() > 0) begin
        e = q_reg.pop_front();
        for (int k = 0; k < 2; k++) begin
          check($sformatf("grill_pos[%0d]", k), gpos[k], e.gp[k]);
          check($sformatf("star_pos[%0d]", k), spos[k], e.sp[k]);
          check($sformatf("fault[%0d]", k), {1'b0, flt[k]}, {1'b0, e.f[k]});
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] c;
    logic       r;
    int         sel;
    rst = 1'b1;
    cmd = 4'b0000;
    repeat (2) drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0000);
    repeat (6) drive(1'b0, 4'b1000);
    repeat (3) drive(1'b0, 4'b0010);
    repeat (4) drive(1'b0, 4'b0100);
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0010);
    drive(1'b0, 4'b1100);
    drive(1'b0, 4'b1010);
    drive(1'b0, 4'b0000);
    repeat (2) drive(1'b0, 4'b1000);
    repeat (5) drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    repeat (12) drive(1'b0, 4'b1000);
    repeat (2) drive(1'b0, 4'b0000);

    repeat (3000) begin
      r   = ($urandom_range(0, 199) == 0);
      sel = $urandom_range(0, 9);
      if (sel <= 6)      c = 4'b0001 << $urandom_range(0, 3);
      else if (sel == 7) c = 4'b0000;
      else               c = 4'($urandom_range(0, 15));
      if (r) c = 4'b0000;
      drive(r, c);
    end
    repeat (2) drive(1'b0, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q_mov.size() != 0 || q_reg.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q_mov.size(), q_reg.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
